duck_motion: RTL and testbench

- Upstream stage of the 13-pixel duck sprite plotter.
- Owns the duck's anchor position (x 8b, y 7b) and per-frame motion: bounces inside the 160x120 screen, falls when shot, respawns.
- Each movement step runs an erase-then-draw sequence. The sprite plotter is given the old anchor with colour black, then the new anchor with colour white, via a start/done handshake.
- Contains its own frame-tick divider.

---
 rtl/duck_motion.sv | 222 ++++++++++++++++++++++
 tb/tb_duck_motion.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/duck_motion.sv
// rtl/duck_motion.sv - duck anchor motion, frame-tick divider and erase/draw request sequencer
module duck_motion #(
  parameter int unsigned FRAME_CYCLES    = 833333,
  parameter int unsigned FRAMES_PER_STEP = 4,
  parameter logic [7:0]  X_START         = 8'd20,
  parameter logic [6:0]  Y_START         = 7'd60,
  parameter logic [7:0]  X_MIN           = 8'd5,
  parameter logic [7:0]  X_MAX           = 8'd159,
  parameter logic [6:0]  Y_MIN           = 7'd3,
  parameter logic [6:0]  Y_MAX           = 7'd116
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       hit,
  input  logic       draw_done,
  output logic       draw_start,
  output logic [7:0] pos_x,
  output logic [6:0] pos_y,
  output logic [2:0] colour,
  output logic       falling,
  output logic       respawned
);

  localparam int unsigned       FC_W    = $clog2(FRAME_CYCLES);
  localparam logic [FC_W-1:0]   FC_LAST = FC_W'(FRAME_CYCLES - 1);
  localparam logic [3:0]        SP_LAST = 4'(FRAMES_PER_STEP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE_REQ,
    S_ERASE_WAIT,
    S_UPDATE,
    S_DRAW_REQ,
    S_DRAW_WAIT
  } state_t;

  state_t          state_q;
  logic [FC_W-1:0] frame_cnt_q;
  logic [3:0]      step_cnt_q;
  logic            step_due_q;
  logic [7:0]      x_q;
  logic [6:0]      y_q;
  logic            dir_x_q;   // 1 = right (increasing x)
  logic            dir_y_q;   // 1 = up (decreasing y)
  logic            falling_q;
  logic            draw_start_q;
  logic            respawned_q;
  logic [7:0]      pos_x_q;
  logic [6:0]      pos_y_q;
  logic [2:0]      colour_q;

  logic            frame_tick;
  logic            step_wrap;
  logic            step_take;
  logic [7:0]      y_fall;
  logic            fall_done;
  logic [7:0]      x_d;
  logic [6:0]      y_d;
  logic            dir_x_d;
  logic            dir_y_d;
  logic            falling_d;

  assign frame_tick = (frame_cnt_q == FC_LAST);
  assign step_wrap  = frame_tick && (step_cnt_q == SP_LAST);
  assign step_take  = (state_q == S_IDLE) && step_due_q;

  // Falling descent is computed in 8 bits so y near the bottom never wraps to the top
  assign y_fall    = {1'b0, y_q} + 8'd2;
  assign fall_done = (y_fall >= {1'b0, Y_MAX});

  // Free-running frame divider, independent of the sequencer state
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      frame_cnt_q <= '0;
    end else if (frame_tick) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_q + 1'b1;
    end
  end

  // Step counter; a wrap while a step is already pending merges into it (no backlog)
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      step_cnt_q <= '0;
      step_due_q <= 1'b0;
    end else begin
      if (frame_tick) begin
        step_cnt_q <= (step_cnt_q == SP_LAST) ? 4'd0 : step_cnt_q + 4'd1;
      end
      if (step_wrap) begin
        step_due_q <= 1'b1;
      end else if (step_take) begin
        step_due_q <= 1'b0;
      end
    end
  end

  // Next anchor position: bounce within bounds, or descend and respawn when shot
  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    dir_x_d   = dir_x_q;
    dir_y_d   = dir_y_q;
    falling_d = falling_q;
    if (falling_q) begin
      if (fall_done) begin
        x_d       = X_START;
        y_d       = Y_START;
        dir_x_d   = 1'b1;
        dir_y_d   = 1'b1;
        falling_d = 1'b0;
      end else begin
        y_d = y_fall[6:0];
      end
    end else begin
      if (dir_x_q) begin
        if (x_q == X_MAX) begin
          x_d     = X_MAX - 8'd1;
          dir_x_d = 1'b0;
        end else begin
          x_d = x_q + 8'd1;
        end
      end else begin
        if (x_q == X_MIN) begin
          x_d     = X_MIN + 8'd1;
          dir_x_d = 1'b1;
        end else begin
          x_d = x_q - 8'd1;
        end
      end
      if (dir_y_q) begin
        if (y_q == Y_MIN) begin
          y_d     = Y_MIN + 7'd1;
          dir_y_d = 1'b0;
        end else begin
          y_d = y_q - 7'd1;
        end
      end else begin
        if (y_q == Y_MAX) begin
          y_d     = Y_MAX - 7'd1;
          dir_y_d = 1'b1;
        end else begin
          y_d = y_q + 7'd1;
        end
      end
    end
  end

  // Erase-then-draw sequencer; request outputs are loaded on entry to each REQ state
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      x_q          <= X_START;
      y_q          <= Y_START;
      dir_x_q      <= 1'b1;
      dir_y_q      <= 1'b1;
      falling_q    <= 1'b0;
      draw_start_q <= 1'b0;
      respawned_q  <= 1'b0;
      pos_x_q      <= X_START;
      pos_y_q      <= Y_START;
      colour_q     <= 3'b111;
    end else begin
      draw_start_q <= 1'b0;
      respawned_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (step_due_q) begin
            falling_q    <= falling_q | hit;
            draw_start_q <= 1'b1;
            pos_x_q      <= x_q;
            pos_y_q      <= y_q;
            colour_q     <= 3'b000;
            state_q      <= S_ERASE_REQ;
          end
        end
        S_ERASE_REQ: begin
          state_q <= S_ERASE_WAIT;
        end
        S_ERASE_WAIT: begin
          if (draw_done) begin
            // y is frozen here, so the respawn decision can be registered to land in UPDATE
            respawned_q <= falling_q && fall_done;
            state_q     <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          x_q          <= x_d;
          y_q          <= y_d;
          dir_x_q      <= dir_x_d;
          dir_y_q      <= dir_y_d;
          falling_q    <= falling_d;
          draw_start_q <= 1'b1;
          pos_x_q      <= x_d;
          pos_y_q      <= y_d;
          colour_q     <= 3'b111;
          state_q      <= S_DRAW_REQ;
        end
        S_DRAW_REQ: begin
          state_q <= S_DRAW_WAIT;
        end
        S_DRAW_WAIT: begin
          if (draw_done) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign draw_start = draw_start_q;
  assign pos_x      = pos_x_q;
  assign pos_y      = pos_y_q;
  assign colour     = colour_q;
  assign falling    = falling_q;
  assign respawned  = respawned_q;

endmodule

// File: tb/tb_duck_motion.sv
// tb/tb_duck_motion.sv - directed bench for duck_motion with a fixed-latency plotter model
module tb_duck_motion;

  logic       CLOCK_50 = 1'b0;
  logic       resetn;
  logic       hit;
  logic       draw_done = 1'b0;
  logic       draw_start;
  logic [7:0] pos_x;
  logic [6:0] pos_y;
  logic [2:0] colour;
  logic       falling;
  logic       respawned;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int plot_lat = 3;
  int plot_cnt = 0;
  int resp_n = 0;
  int resp_cyc = 0;
  int rec_x[$];
  int rec_y[$];
  int rec_c[$];
  int rec_cyc[$];

  duck_motion #(
    .FRAME_CYCLES   (4),
    .FRAMES_PER_STEP(2)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .resetn    (resetn),
    .hit       (hit),
    .draw_done (draw_done),
    .draw_start(draw_start),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .colour    (colour),
    .falling   (falling),
    .respawned (respawned)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Cycle number since reset release: the first rising edge after release is cycle 1
  always @(posedge CLOCK_50) begin
    if (!resetn) cyc = 0;
    else cyc = cyc + 1;
  end

  // Plotter model and request recorder, on the falling edge away from DUT updates
  always @(negedge CLOCK_50) begin
    draw_done = 1'b0;
    if (!resetn) begin
      plot_cnt = 0;
    end else begin
      if (plot_cnt > 0) begin
        plot_cnt = plot_cnt - 1;
        if (plot_cnt == 0) draw_done = 1'b1;
      end
      if (draw_start) begin
        plot_cnt = plot_lat;
        rec_x.push_back(int'(pos_x));
        rec_y.push_back(int'(pos_y));
        rec_c.push_back(int'(colour));
        rec_cyc.push_back(cyc);
      end
      if (respawned) begin
        resp_n   = resp_n + 1;
        resp_cyc = cyc;
      end
    end
  end

  task automatic wait_rec(input int n);
    int budget = 4000;
    while (rec_x.size() < n && budget > 0) begin
      @(posedge CLOCK_50);
      #1;
      budget--;
    end
    if (rec_x.size() < n) begin
      checks++;
      errors++;
      $display("FAIL wait_rec: got %0d requests, required %0d", rec_x.size(), n);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  endtask

  task automatic test_reset();
    resetn   = 1'b0;
    hit      = 1'b0;
    plot_lat = 3;
    repeat (3) @(posedge CLOCK_50);
    #1;
    checks++;
    if (draw_start !== 1'b0 || respawned !== 1'b0 || falling !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: start=%b resp=%b fall=%b required 0 0 0", draw_start, respawned, falling);
    end
    checks++;
    if (colour !== 3'b111 || pos_x !== 8'd20 || pos_y !== 7'd60) begin
      errors++;
      $display("FAIL reset_pos: colour=%0d pos=(%0d,%0d) required 7 (20,60)", colour, pos_x, pos_y);
    end
    @(negedge CLOCK_50);
    resetn = 1'b1;
  endtask

  task automatic test_first_step();
    wait_rec(2);
    checks++;
    if (rec_cyc[0] !== 9) begin
      errors++;
      $display("FAIL first_cycle: got %0d required 9", rec_cyc[0]);
    end
    checks++;
    if (rec_c[0] !== 0 || rec_x[0] !== 20 || rec_y[0] !== 60) begin
      errors++;
      $display("FAIL first_erase: got c=%0d (%0d,%0d) required c=0 (20,60)", rec_c[0], rec_x[0], rec_y[0]);
    end
    checks++;
    if (rec_c[1] !== 7 || rec_x[1] !== 21 || rec_y[1] !== 59) begin
      errors++;
      $display("FAIL first_draw: got c=%0d (%0d,%0d) required c=7 (21,59)", rec_c[1], rec_x[1], rec_y[1]);
    end
  endtask

  task automatic test_y_bounce();
    int ix[3] = '{113, 114, 115};
    int ex[3] = '{77, 77, 78};
    int ey[3] = '{3, 3, 4};
    int ec[3] = '{7, 0, 7};
    wait_rec(116);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rec_x[ix[i]] !== ex[i] || rec_y[ix[i]] !== ey[i] || rec_c[ix[i]] !== ec[i]) begin
        errors++;
        $display("FAIL y_bounce[%0d]: got c=%0d (%0d,%0d) required c=%0d (%0d,%0d)", ix[i],
                 rec_c[ix[i]], rec_x[ix[i]], rec_y[ix[i]], ec[i], ex[i], ey[i]);
      end
    end
  endtask

  task automatic test_x_bounce();
    int ix[3] = '{277, 278, 279};
    int ex[3] = '{159, 159, 158};
    int ey[3] = '{85, 85, 86};
    int ec[3] = '{7, 0, 7};
    wait_rec(280);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rec_x[ix[i]] !== ex[i] || rec_y[ix[i]] !== ey[i] || rec_c[ix[i]] !== ec[i]) begin
        errors++;
        $display("FAIL x_bounce[%0d]: got c=%0d (%0d,%0d) required c=%0d (%0d,%0d)", ix[i],
                 rec_c[ix[i]], rec_x[ix[i]], rec_y[ix[i]], ec[i], ex[i], ey[i]);
      end
    end
  endtask

  task automatic test_falling();
    int ix[6] = '{280, 281, 283, 307, 308, 309};
    int ex[6] = '{158, 158, 158, 158, 158, 20};
    int ey[6] = '{86, 88, 90, 114, 114, 60};
    int ec[6] = '{0, 7, 7, 7, 0, 7};
    checks++;
    if (falling !== 1'b0) begin
      errors++;
      $display("FAIL fall_before: got %b required 0", falling);
    end
    hit = 1'b1;
    wait_rec(281);
    hit = 1'b0;
    checks++;
    if (falling !== 1'b1) begin
      errors++;
      $display("FAIL fall_latched: got %b required 1", falling);
    end
    wait_rec(310);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (rec_x[ix[i]] !== ex[i] || rec_y[ix[i]] !== ey[i] || rec_c[ix[i]] !== ec[i]) begin
        errors++;
        $display("FAIL fall_path[%0d]: got c=%0d (%0d,%0d) required c=%0d (%0d,%0d)", ix[i],
                 rec_c[ix[i]], rec_x[ix[i]], rec_y[ix[i]], ec[i], ex[i], ey[i]);
      end
    end
    checks++;
    if (resp_n !== 1 || resp_cyc !== rec_cyc[309] - 1) begin
      errors++;
      $display("FAIL respawn_pulse: got n=%0d cyc=%0d required n=1 cyc=%0d", resp_n, resp_cyc, rec_cyc[309] - 1);
    end
    wait_rec(312);
    checks++;
    if (falling !== 1'b0 || rec_x[311] !== 21 || rec_y[311] !== 59) begin
      errors++;
      $display("FAIL after_respawn: got fall=%b (%0d,%0d) required 0 (21,59)", falling, rec_x[311], rec_y[311]);
    end
  endtask

  task automatic test_stall();
    int lo;
    int n_erase = 0;
    int budget = 200;
    plot_lat = 40;
    wait_rec(313);
    plot_lat = 1;
    for (int i = 0; i < 36; i++) begin
      checks++;
      if (draw_start !== 1'b0 || pos_x !== 8'd21 || pos_y !== 7'd59 || colour !== 3'b000) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got start=%b c=%0d (%0d,%0d) required 0 c=0 (21,59)",
                 i, draw_start, colour, pos_x, pos_y);
      end
      @(posedge CLOCK_50);
      #1;
    end
    wait_rec(315);
    checks++;
    if (rec_x[313] !== 22 || rec_y[313] !== 58 || rec_c[313] !== 7) begin
      errors++;
      $display("FAIL stall_draw: got c=%0d (%0d,%0d) required c=7 (22,58)", rec_c[313], rec_x[313], rec_y[313]);
    end
    checks++;
    if (rec_cyc[314] - rec_cyc[313] !== 3 || rec_c[314] !== 0) begin
      errors++;
      $display("FAIL pending_step: got gap=%0d c=%0d required gap=3 c=0", rec_cyc[314] - rec_cyc[313], rec_c[314]);
    end
    lo = rec_cyc[313];
    while (cyc <= lo + 41 && budget > 0) begin
      @(posedge CLOCK_50);
      #1;
      budget--;
    end
    for (int i = 0; i < rec_cyc.size(); i++) begin
      if (rec_cyc[i] > lo && rec_cyc[i] <= lo + 40 && rec_c[i] == 0) n_erase++;
    end
    checks++;
    if (n_erase < 4 || n_erase > 6) begin
      errors++;
      $display("FAIL tick_drop: got %0d steps in 40 cycles, required 4..6", n_erase);
    end
  endtask

  task automatic test_reset_mid();
    int n0 = rec_x.size();
    wait_rec(n0 + 1);
    if (rec_c[rec_c.size() - 1] == 0) wait_rec(n0 + 2);
    #1;
    resetn = 1'b0;
    #1;
    checks++;
    if (draw_start !== 1'b0 || colour !== 3'b111 || pos_x !== 8'd20 || pos_y !== 7'd60 ||
        falling !== 1'b0 || respawned !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got start=%b c=%0d (%0d,%0d) fall=%b resp=%b required 0 7 (20,60) 0 0",
               draw_start, colour, pos_x, pos_y, falling, respawned);
    end
    rec_x.delete();
    rec_y.delete();
    rec_c.delete();
    rec_cyc.delete();
    plot_lat = 3;
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    resetn = 1'b1;
    test_first_step();
  endtask

  initial begin
    test_reset();
    test_first_step();
    test_y_bounce();
    test_x_bounce();
    test_falling();
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
